// File: rtl/one_b_comparator.sv
// ---------------------------------------------------------------------------
// one_b_comparator
// Registered magnitude comparator with cascade inputs. Reports exactly one of
// lessThan / equalTo / moreThan for operand `compared` (A) against operand
// `comparer` (B), one cycle after an in_valid edge.
//
// Build option:
//   COMPARATOR_SIGNED_EN  - when defined, operands are two's complement.
//                           When undefined (default), compare is unsigned.
//
// The operand compare is MSB-first, built as a balanced binary tree of
// (greater, less) pairs so depth grows with log2(WIDTH), not WIDTH.
// ---------------------------------------------------------------------------
module one_b_comparator #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] compared,
   input  logic [WIDTH-1:0] comparer,
   input  logic             casc_lt,
   input  logic             casc_eq,
   input  logic             casc_gt,
   output logic             out_valid,
   output logic             lessThan,
   output logic             equalTo,
   output logic             moreThan
);

`ifdef COMPARATOR_SIGNED_EN
   localparam bit SignedCmp = 1'b1;
`else
   localparam bit SignedCmp = 1'b0;
`endif

   // Tree geometry: leaves padded up to a power of two; padded leaves are
   // "undecided" (gt=0, lt=0) so they never influence the result.
   localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
   localparam int NP     = 1 << LEVELS;

   // Per-level decision vectors; node j of level l covers leaves
   // [j*2^l +: 2^l]. Only the low NP>>l bits of each level are meaningful.
   logic [NP-1:0] gtTree [LEVELS+1];
   logic [NP-1:0] ltTree [LEVELS+1];

   logic opGt;
   logic opLt;
   logic [2:0] resNext;   // {lt, eq, gt}

   logic vld_p1;
   logic lt_p1;
   logic eq_p1;
   logic gt_p1;

   // Resolve a tie on the operands using the lower-significance slice's
   // verdict. Priority: eq > lt > gt > none (none reads as equal).
   function automatic logic [2:0] resolveCascade(
      input logic isGt,
      input logic isLt,
      input logic cLt,
      input logic cEq,
      input logic cGt
   );
      logic [2:0] res;
      if (isGt)
         res = 3'b001;
      else if (isLt)
         res = 3'b100;
      else if (cEq)
         res = 3'b010;
      else if (cLt)
         res = 3'b100;
      else if (cGt)
         res = 3'b001;
      else
         res = 3'b010;
      return res;
   endfunction

   // Balanced MSB-first reduction of the operand bits into a single verdict.
   always_comb begin
      for (int l = 0; l <= LEVELS; l++) begin
         gtTree[l] = '0;
         ltTree[l] = '0;
      end

      // Leaves: per-bit verdict. In the signed build the sign bit is
      // inverted in meaning: A having the sign set makes A the smaller one.
      for (int i = 0; i < WIDTH; i++) begin
         if (SignedCmp && (i == WIDTH - 1)) begin
            gtTree[0][i] = ~compared[i] &  comparer[i];
            ltTree[0][i] =  compared[i] & ~comparer[i];
         end else begin
            gtTree[0][i] =  compared[i] & ~comparer[i];
            ltTree[0][i] = ~compared[i] &  comparer[i];
         end
      end

      // Combine pairs: the more significant child wins if it has decided,
      // otherwise the less significant child's verdict passes through.
      for (int l = 0; l < LEVELS; l++) begin
         for (int j = 0; j < (NP >> (l + 1)); j++) begin
            gtTree[l+1][j] = gtTree[l][2*j+1] |
                             (~ltTree[l][2*j+1] & gtTree[l][2*j]);
            ltTree[l+1][j] = ltTree[l][2*j+1] |
                             (~gtTree[l][2*j+1] & ltTree[l][2*j]);
         end
      end

      opGt    = gtTree[LEVELS][0];
      opLt    = ltTree[LEVELS][0];
      resNext = resolveCascade(opGt, opLt, casc_lt, casc_eq, casc_gt);
   end

   // ---- stage p0 -> p1 boundary: result registers ----
   // Capture a new verdict on in_valid; flags hold when no new operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         lt_p1  <= 1'b0;
         eq_p1  <= 1'b0;
         gt_p1  <= 1'b0;
      end else if (in_valid) begin
         vld_p1 <= 1'b1;
         lt_p1  <= resNext[2];
         eq_p1  <= resNext[1];
         gt_p1  <= resNext[0];
      end else begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign lessThan  = lt_p1;
   assign equalTo   = eq_p1;
   assign moreThan  = gt_p1;

endmodule

// File: tb/tb_one_b_comparator.sv
// ---------------------------------------------------------------------------
// tb_one_b_comparator
// Directed and random checks of one_b_comparator at WIDTH = 1, 8 and 16.
// Honours COMPARATOR_SIGNED_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_one_b_comparator;

`ifdef COMPARATOR_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // WIDTH=1 instance
   logic       v1, lt1c, eq1c, gt1c;
   logic [0:0] a1, b1;
   logic       ov1, lo1, eo1, go1;
   // WIDTH=8 instance
   logic       v8, lt8c, eq8c, gt8c;
   logic [7:0] a8, b8;
   logic       ov8, lo8, eo8, go8;
   // WIDTH=16 instance
   logic        v16, lt16c, eq16c, gt16c;
   logic [15:0] a16, b16;
   logic        ov16, lo16, eo16, go16;

   int checks = 0;
   int errors = 0;

   one_b_comparator #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .compared(a1), .comparer(b1),
      .casc_lt(lt1c), .casc_eq(eq1c), .casc_gt(gt1c),
      .out_valid(ov1), .lessThan(lo1), .equalTo(eo1), .moreThan(go1));

   one_b_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .compared(a8), .comparer(b8),
      .casc_lt(lt8c), .casc_eq(eq8c), .casc_gt(gt8c),
      .out_valid(ov8), .lessThan(lo8), .equalTo(eo8), .moreThan(go8));

   one_b_comparator #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .compared(a16), .comparer(b16),
      .casc_lt(lt16c), .casc_eq(eq16c), .casc_gt(gt16c),
      .out_valid(ov16), .lessThan(lo16), .equalTo(eo16), .moreThan(go16));

   // Advance one edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; lt1c = 1'b0; eq1c = 1'b1; gt1c = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({ov1, lo1, eo1, go1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_cycle%0d: got {v,lt,eq,gt}=%b want 0000", i, {ov1, lo1, eo1, go1});
         end
         checks++;
         if ({ov8, ov16} !== 2'b00) begin
            errors++;
            $display("FAIL reset_wide_valid: got %b want 00", {ov8, ov16});
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      // Unsigned: 1 > 0. Signed: 1 is -1, so -1 < 0.
      if ({ov1, lo1, eo1, go1} !== (SGN ? 4'b1100 : 4'b1001)) begin
         errors++;
         $display("FAIL reset_release: got {v,lt,eq,gt}=%b want %b", {ov1, lo1, eo1, go1}, SGN ? 4'b1100 : 4'b1001);
      end
   endtask

   task automatic test_sweep_w1();
      logic [1:0] ops  [4];
      logic [2:0] expU [4];
      logic [2:0] expS [4];
      logic [2:0] want;
      ops[0] = 2'b00; expU[0] = 3'b010; expS[0] = 3'b010;
      ops[1] = 2'b01; expU[1] = 3'b100; expS[1] = 3'b001; // 0 vs -1
      ops[2] = 2'b10; expU[2] = 3'b001; expS[2] = 3'b100; // -1 vs 0
      ops[3] = 2'b11; expU[3] = 3'b010; expS[3] = 3'b010;
      lt1c = 1'b0; eq1c = 1'b1; gt1c = 1'b0; v1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a1 = ops[i][1];
         b1 = ops[i][0];
         tick();
         want = SGN ? expS[i] : expU[i];
         checks++;
         if ({ov1, lo1, eo1, go1} !== {1'b1, want}) begin
            errors++;
            $display("FAIL sweep_w1 a=%b b=%b: got {v,lt,eq,gt}=%b want %b", a1, b1, {ov1, lo1, eo1, go1}, {1'b1, want});
         end
      end
   endtask

   task automatic test_hold();
      logic [2:0] want;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
      tick();
      want = SGN ? 3'b100 : 3'b001;
      checks++;
      if ({ov1, lo1, eo1, go1} !== {1'b1, want}) begin
         errors++;
         $display("FAIL hold_setup: got %b want %b", {ov1, lo1, eo1, go1}, {1'b1, want});
      end
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({ov1, lo1, eo1, go1} !== {1'b0, want}) begin
            errors++;
            $display("FAIL hold_cycle%0d: got {v,lt,eq,gt}=%b want %b", i, {ov1, lo1, eo1, go1}, {1'b0, want});
         end
      end
   endtask

   task automatic test_cascade();
      logic [7:0] va [5];
      logic [7:0] vb [5];
      logic [2:0] cs [5];   // {lt, eq, gt}
      logic [2:0] ex [5];   // {lt, eq, gt}
      va[0] = 8'h5A; vb[0] = 8'h5A; cs[0] = 3'b100; ex[0] = 3'b100;
      va[1] = 8'h5A; vb[1] = 8'h5A; cs[1] = 3'b001; ex[1] = 3'b001;
      va[2] = 8'h5A; vb[2] = 8'h5A; cs[2] = 3'b000; ex[2] = 3'b010;
      va[3] = 8'h5B; vb[3] = 8'h5A; cs[3] = 3'b100; ex[3] = 3'b001;
      va[4] = 8'h5A; vb[4] = 8'h5A; cs[4] = 3'b111; ex[4] = 3'b010;
      v8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a8 = va[i]; b8 = vb[i];
         lt8c = cs[i][2]; eq8c = cs[i][1]; gt8c = cs[i][0];
         tick();
         checks++;
         if ({ov8, lo8, eo8, go8} !== {1'b1, ex[i]}) begin
            errors++;
            $display("FAIL cascade%0d a=%h b=%h casc=%b: got %b want %b", i, va[i], vb[i], cs[i], {ov8, lo8, eo8, go8}, {1'b1, ex[i]});
         end
      end
      // Cascade inputs unknown while operands differ must not leak into the result.
      a8 = 8'h10; b8 = 8'h20; lt8c = 1'bx; eq8c = 1'bx; gt8c = 1'bx;
      tick();
      checks++;
      if ({ov8, lo8, eo8, go8} !== 4'b1100) begin
         errors++;
         $display("FAIL cascade_x_ignored: got %b want 1100", {ov8, lo8, eo8, go8});
      end
   endtask

   task automatic test_boundary();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      logic [2:0] exU [4];
      logic [2:0] exS [4];
      logic [2:0] want;
      va[0] = 8'h80; vb[0] = 8'h7F; exU[0] = 3'b001; exS[0] = 3'b100;
      va[1] = 8'hFF; vb[1] = 8'h00; exU[1] = 3'b001; exS[1] = 3'b100;
      va[2] = 8'h00; vb[2] = 8'hFF; exU[2] = 3'b100; exS[2] = 3'b001;
      va[3] = 8'hFE; vb[3] = 8'hFF; exU[3] = 3'b100; exS[3] = 3'b100;
      v8 = 1'b1; lt8c = 1'b0; eq8c = 1'b1; gt8c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a8 = va[i]; b8 = vb[i];
         tick();
         want = SGN ? exS[i] : exU[i];
         checks++;
         if ({ov8, lo8, eo8, go8} !== {1'b1, want}) begin
            errors++;
            $display("FAIL boundary a=%h b=%h: got %b want %b", va[i], vb[i], {ov8, lo8, eo8, go8}, {1'b1, want});
         end
      end
      v8 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [2:0] held;
      logic [2:0] want;
      logic       vNow;
      logic [2:0] c;
      held = 3'b000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         vNow = ($urandom_range(0, 3) != 0);
         v16 = vNow;
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) b16 = a16;
         c = 3'($urandom);
         lt16c = c[2]; eq16c = c[1]; gt16c = c[0];
         if (SGN ? ($signed(a16) < $signed(b16)) : (a16 < b16))
            want = 3'b100;
         else if (SGN ? ($signed(a16) > $signed(b16)) : (a16 > b16))
            want = 3'b001;
         else if (c[1])
            want = 3'b010;
         else if (c[2])
            want = 3'b100;
         else if (c[0])
            want = 3'b001;
         else
            want = 3'b010;
         if (vNow) held = want;
         tick();
         checks++;
         if ({ov16, lo16, eo16, go16} !== {vNow, held}) begin
            errors++;
            $display("FAIL random%0d a=%h b=%h casc=%b v=%b: got %b want %b", n, a16, b16, c, vNow, {ov16, lo16, eo16, go16}, {vNow, held});
         end
         if (ov16 === 1'b1) begin
            checks++;
            if (({2'b00, lo16} + {2'b00, eo16} + {2'b00, go16}) !== 3'd1) begin
               errors++;
               $display("FAIL onehot%0d: got flags %b want exactly one set", n, {lo16, eo16, go16});
            end
         end
      end
      v16 = 1'b0;
   endtask

   initial begin
      v1 = 1'b0; a1 = '0; b1 = '0; lt1c = 1'b0; eq1c = 1'b1; gt1c = 1'b0;
      v8 = 1'b0; a8 = '0; b8 = '0; lt8c = 1'b0; eq8c = 1'b1; gt8c = 1'b0;
      v16 = 1'b0; a16 = '0; b16 = '0; lt16c = 1'b0; eq16c = 1'b1; gt16c = 1'b0;
      test_reset();
      test_sweep_w1();
      test_hold();
      test_cascade();
      test_boundary();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
